// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared types and constants for the EX->MEM pipeline stage.
//   - XLEN / REG_AW       : datapath and register-index widths
//   - FLAG_ZERO/FLAG_SIGN : bit positions inside the 2-bit ALU flag vector
//   - ex_mem_ctrl_t       : writeback / memory control bits
//   - ex_mem_payload_t    : everything the stage carries from EX to MEM
//   - skid_state_e        : occupancy state of the 2-entry skid buffer
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_SIGN = 1;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [1:0]        flag;
        logic [REG_AW-1:0] rd;
        ex_mem_ctrl_t      ctrl;
        logic [XLEN-1:0]   store_data;
    } ex_mem_payload_t;

    localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,  // nothing held
        SKID_ONE   = 2'd1,  // main register valid
        SKID_TWO   = 2'd2   // main + skid registers valid
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
//   Generic 2-entry valid/ready pipeline buffer. The downstream side is
//   always driven from the main register; a second (skid) register absorbs
//   the one extra beat that arrives while the registered in_ready is still
//   high, so out_ready never reaches in_ready combinationally.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous squash of every held entry
//   in_valid/in_ready   upstream handshake (in_ready is a register)
//   in_data  [W-1:0]    upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [W-1:0]    downstream payload (main register)
// ---------------------------------------------------------------------------
module pipe_skid_buf
    import riscv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state, state_next;
    logic [W-1:0] main_q, skid_q;
    logic         push, pop;
    logic         load_main_in, load_main_skid, load_skid;

    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            SKID_EMPTY: begin
                if (push) begin
                    state_next   = SKID_ONE;
                    load_main_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (push && !pop) begin
                    state_next = SKID_TWO;
                    load_skid  = 1'b1;
                end else if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (pop) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_next     = SKID_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
        // Flush wins over any push/pop: the pop still completes downstream
        // (it is observed this cycle) but nothing new is captured.
        if (flush) begin
            state_next     = SKID_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SKID_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != SKID_TWO);
        end
    end

    // NOTE: payload registers are reset too: the main register is visible on
    // the outputs and must read zero out of reset; the skid register is reset
    // so its contents are never X in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)
                main_q <= in_data;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_data;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX->MEM pipeline register directly after the ALU. Packs the ALU result,
//   flags and writeback/memory controls into one payload and passes it
//   through a 2-entry skid buffer (1-cycle latency, strict FIFO order).
//   Payload passes through unmodified; rd==0 is forwarded as-is.
// Ports
//   clk, rst_n, flush        clock, async active-low reset, sync squash
//   in_valid / in_ready      EX-side handshake (in_ready registered)
//   ALUresult, Flag, rd, reg_write, mem_read, mem_write, store_data
//                            EX-side payload (Flag[0]=zero, Flag[1]=sign)
//   out_valid / out_ready    MEM-side handshake
//   out_result, out_flag, out_rd, out_reg_write, out_mem_read,
//   out_mem_write, out_store_data   held payload toward MEM
//   stall_cnt [31:0]         only with EXMEM_STALL_CNT_EN: saturating count
//                            of cycles with out_valid & !out_ready, cleared
//                            by reset only
// Configuration macro: EXMEM_STALL_CNT_EN
// ---------------------------------------------------------------------------
module ex_mem_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   ALUresult,
    input  logic [1:0]        Flag,
    input  logic [REG_AW-1:0] rd,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [XLEN-1:0]   store_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [1:0]        out_flag,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [XLEN-1:0]   out_store_data
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    ex_mem_payload_t pl_in, pl_out;

    always_comb begin
        pl_in                = '0;
        pl_in.result         = ALUresult;
        pl_in.flag[FLAG_ZERO] = Flag[FLAG_ZERO];
        pl_in.flag[FLAG_SIGN] = Flag[FLAG_SIGN];
        pl_in.rd             = rd;
        pl_in.ctrl.reg_write = reg_write;
        pl_in.ctrl.mem_read  = mem_read;
        pl_in.ctrl.mem_write = mem_write;
        pl_in.store_data     = store_data;
    end

    pipe_skid_buf #(
        .W (EX_MEM_PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pl_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pl_out)
    );

    assign out_result     = pl_out.result;
    assign out_flag       = pl_out.flag;
    assign out_rd         = pl_out.rd;
    assign out_reg_write  = pl_out.ctrl.reg_write;
    assign out_mem_read   = pl_out.ctrl.mem_read;
    assign out_mem_write  = pl_out.ctrl.mem_write;
    assign out_store_data = pl_out.store_data;

`ifdef EXMEM_STALL_CNT_EN
    // Flush deliberately does not clear the counter; it measures MEM stalls
    // over the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Scoreboard bench for ex_mem_stage: every accepted payload is queued, every
//   MEM-side pop is compared against the queue head. Directed sequences cover
//   reset, streaming, backpressure, flush, payload integrity, optional stall
//   counter and reset while full.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;
    import riscv_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   ALUresult;
    logic [1:0]        Flag;
    logic [REG_AW-1:0] rd;
    logic              reg_write, mem_read, mem_write;
    logic [XLEN-1:0]   store_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic [1:0]        out_flag;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_write, out_mem_read, out_mem_write;
    logic [XLEN-1:0]   out_store_data;
`ifdef EXMEM_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ex_mem_payload_t sb_q[$];
    ex_mem_payload_t sb_exp;
    ex_mem_payload_t cur_in;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ALUresult      (ALUresult),
        .Flag           (Flag),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .store_data     (store_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_flag       (out_flag),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_store_data (out_store_data)
`ifdef EXMEM_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always_comb begin
        cur_in                = '0;
        cur_in.result         = ALUresult;
        cur_in.flag           = Flag;
        cur_in.rd             = rd;
        cur_in.ctrl.reg_write = reg_write;
        cur_in.ctrl.mem_read  = mem_read;
        cur_in.ctrl.mem_write = mem_write;
        cur_in.store_data     = store_data;
    end

    // Inputs change just after posedge, so at negedge they hold the values
    // the DUT will see at the coming posedge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_spurious_pop", sb_q.size(), 1);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check("sb_result",     out_result,     sb_exp.result);
                    check("sb_flag",       out_flag,       sb_exp.flag);
                    check("sb_rd",         out_rd,         sb_exp.rd);
                    check("sb_reg_write",  out_reg_write,  sb_exp.ctrl.reg_write);
                    check("sb_mem_read",   out_mem_read,   sb_exp.ctrl.mem_read);
                    check("sb_mem_write",  out_mem_write,  sb_exp.ctrl.mem_write);
                    check("sb_store_data", out_store_data, sb_exp.store_data);
                end
            end
            if (flush)
                sb_q.delete();
            else if (in_valid && in_ready)
                sb_q.push_back(cur_in);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] res);
        in_valid   = v;
        ALUresult  = res;
        Flag       = 2'($urandom_range(0, 3));
        rd         = 5'($urandom_range(0, 31));
        reg_write  = 1'($urandom_range(0, 1));
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
        store_data = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0);
        #12;
        check("reset_out_valid",  out_valid,  0);
        check("reset_in_ready",   in_ready,   1);
        check("reset_out_result", out_result, 0);
        check("reset_out_store",  out_store_data, 0);
        rst_n = 1'b1;
        step();

        // Streaming with MEM always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, XLEN'(i));
            step();
            check("stream_in_ready", in_ready, 1);
            check("stream_out", out_result, i);
        end
        drive(1'b0, '0);
        step();
        check("stream_drained", out_valid, 0);

        // Backpressure fills both entries.
        out_ready = 1'b0;
        drive(1'b1, 32'hA);
        step();
        check("bp_ready_one", in_ready, 1);
        drive(1'b1, 32'hB);
        step();
        check("bp_ready_two", in_ready, 0);
        check("bp_hold_a",    out_result, 32'hA);
        drive(1'b0, '0);
        step();
        check("bp_still_a",   out_result, 32'hA);
        check("bp_valid",     out_valid, 1);
        out_ready = 1'b1;
        step();
        check("bp_out_b",     out_result, 32'hB);
        check("bp_ready_back", in_ready, 1);
        step();
        check("bp_empty",     out_valid, 0);

        // Flush in TWO with an offered payload.
        out_ready = 1'b0;
        drive(1'b1, 32'h1); step();
        drive(1'b1, 32'h2); step();
        drive(1'b1, 32'hC); flush = 1'b1;
        step();
        flush = 1'b0; drive(1'b0, '0);
        check("flush_two_valid", out_valid, 0);
        check("flush_two_ready", in_ready, 1);

        // Flush in ONE with a push and a pop on the same cycle.
        drive(1'b1, 32'h3); step();
        out_ready = 1'b1;
        drive(1'b1, 32'hD); flush = 1'b1;
        step();
        flush = 1'b0; drive(1'b0, '0);
        check("flush_one_valid", out_valid, 0);
        repeat (3) step();

        // Payload integrity.
        in_valid = 1'b1; ALUresult = 32'h1234_5678; Flag = 2'b01; rd = 5'd31;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b1; store_data = 32'hDEAD_BEEF;
        step();
        check("pi_result", out_result, 32'h1234_5678);
        check("pi_flag",   out_flag, 2'b01);
        check("pi_rd",     out_rd, 31);
        check("pi_mw",     out_mem_write, 1);
        check("pi_sd",     out_store_data, 32'hDEAD_BEEF);
        rd = 5'd0; reg_write = 1'b1; mem_write = 1'b0; Flag = 2'b10; ALUresult = 32'h8000_0000;
        step();
        check("pi_x0_rd", out_rd, 0);
        check("pi_x0_rw", out_reg_write, 1);
        check("pi_x0_fl", out_flag, 2'b10);
        drive(1'b0, '0);
        step();

        // Stall counter: fresh reset, 5 stalled cycles, flush while popping.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step();
`ifdef EXMEM_STALL_CNT_EN
        check("stall_reset", stall_cnt, 0);
`endif
        out_ready = 1'b0;
        drive(1'b1, 32'h55);
        step();
        drive(1'b0, '0);
        repeat (5) step();
`ifdef EXMEM_STALL_CNT_EN
        check("stall_five", stall_cnt, 5);
`endif
        check("stall_hold", out_result, 32'h55);
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef EXMEM_STALL_CNT_EN
        check("stall_after_flush", stall_cnt, 5);
`endif
        check("stall_flush_valid", out_valid, 0);
        step();
        check("sb_drain", sb_q.size(), 0);

        // Reset in the middle of traffic while full.
        out_ready = 1'b0;
        drive(1'b1, 32'h11); step();
        drive(1'b1, 32'h22); step();
        drive(1'b0, '0);
        check("mid_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  out_valid, 0);
        check("mid_rst_ready",  in_ready, 1);
        check("mid_rst_result", out_result, 0);
        #1 rst_n = 1'b1;
        step();
        check("mid_rst_after", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
